tanh_job_issuer: RTL
====================

TANH_JOB_ISSUER -- requirements
Module: tanh_job_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning input FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the watchdog limit in clocks (used only with the macro).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  an upstream sample is offered.
REQ-006 SHALL have port in_ready  output  1  the FIFO can accept a sample (not full).
REQ-007 SHALL have port in_data  input  17  the x operand.
REQ-008 SHALL have port core_start  output  1  a one-cycle start pulse to the tanh core.
REQ-009 SHALL have port core_data_x  output  17  the operand to the core.
REQ-010 SHALL have port core_done  input  1  core completion pulse.
REQ-011 SHALL have port core_result  input  32  the core result, valid while core_done=1.
REQ-012 SHALL have port out_valid  output  1  a result is held for downstream.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_data  output  32  the captured result.
REQ-015 SHALL have port busy  output  1  the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-016 SHALL push in_data on every clock edge where in_valid&&in_ready; in_ready=0 exactly when DEPTH entries are occupied.
REQ-017 SHALL implement FSM states IDLE, START, WAIT, HOLD.
REQ-018 IDLE->START SHALL occur when the FIFO is non-empty and out_valid=0; that pop loads core_data_x.
REQ-019 In START, core_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-020 core_data_x SHALL stay stable from START until the WAIT exit.
REQ-021 core_done SHALL be sampled only in WAIT; a core_done in IDLE, START or HOLD SHALL be ignored.
REQ-022 WAIT with core_done=1 SHALL capture core_result into out_data, set out_valid=1 and go to HOLD.
REQ-023 HOLD SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-024 On out_ready=1 in HOLD, out_valid SHALL clear next cycle and the FSM SHALL go to IDLE.
REQ-025 Issue latency: the fastest start follows the push by 2 cycles (push edge, then IDLE pop edge, then core_start high).
REQ-026 A push and a pop in the same cycle SHALL both take effect, with the occupancy unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-028 Jobs SHALL complete in strict FIFO order, with at most one job outstanding at the core.

Reset
REQ-029 While rst=1: FSM=IDLE, FIFO empty, core_start=0, core_data_x=0, out_valid=0, out_data=0, busy=0.
REQ-030 in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-031 Reset mid-job SHALL discard the queued job and the in-flight job; a later stray core_done SHALL be ignored per REQ-021.

Configuration
REQ-032 With TANH_ISSUER_TIMEOUT_EN defined, a WAIT cycle counter SHALL run. When it reaches TIMEOUT_CYCLES without core_done: out_data=32'hFFFF_FFFF, out_valid=1, go to HOLD, and a sticky output timeout_err (1 bit, cleared only by rst) SHALL set.
REQ-033 Without the macro there SHALL be no counter and no timeout_err port, and WAIT SHALL wait indefinitely.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, XW=17, RW=32 and the timeout sentinel value.
REQ-035 The FIFO SHALL be one sub-module, tanh_issuer_fifo (parameter DEPTH, width XW).

Verification
REQ-036 Stub core with done 10 cycles after start and result=x+1. Push 17'd14566 -> core_start pulse with core_data_x=14566, then out_data=14567 with out_valid=1.
REQ-037 Push 14566, 1987, 5, 7 back-to-back with out_ready=1 -> in_ready stays 1; outputs 14567, 1988, 6, 8 in order; exactly 4 start pulses.
REQ-038 Push 5 samples with DEPTH=4 and the core stalled -> in_ready drops after the FIFO holds 4 (one job in flight); no sample is lost once the core resumes.
REQ-039 Hold out_ready=0 for 20 cycles -> out_data stays constant and no new core_start occurs; releasing out_ready lets the next job issue.
REQ-040 Assert rst 3 cycles into WAIT, then the stub's done arrives -> all outputs at reset values; out_valid stays 0.
REQ-041 With TANH_ISSUER_TIMEOUT_EN, the stub never asserts done -> after 64 WAIT cycles out_data=32'hFFFF_FFFF, timeout_err=1, and the next job still processes.

Source files
------------

// File: rtl/tanh_job_issuer_pkg.sv
// rtl/tanh_job_issuer_pkg.sv - shared widths, FSM state enum and timeout sentinel for the tanh job issuer
package tanh_job_issuer_pkg;

  localparam int XW = 17;
  localparam int RW = 32;

  localparam logic [RW-1:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } issuer_state_e;

endpackage

// File: rtl/tanh_issuer_fifo.sv
// rtl/tanh_issuer_fifo.sv - operand FIFO; pointers carry one extra bit so full and empty differ
module tanh_issuer_fifo
  import tanh_job_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [XW-1:0] push_data,
  input  logic          pop,
  output logic [XW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [XW-1:0] mem_q [DEPTH];
  logic [XW-1:0] mem_d [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW + 1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Same low bits: equal wrap bits means empty, differing wrap bits means full.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/tanh_job_issuer.sv
// rtl/tanh_job_issuer.sv - queues x operands and issues them one at a time to a tanh core
// Optional WAIT watchdog and sticky timeout_err port: define TANH_ISSUER_TIMEOUT_EN.
module tanh_job_issuer
  import tanh_job_issuer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_data,
  output logic          core_start,
  output logic [XW-1:0] core_data_x,
  input  logic          core_done,
  input  logic [RW-1:0] core_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
`ifdef TANH_ISSUER_TIMEOUT_EN
  output logic          timeout_err,
`endif
  output logic          busy
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("tanh_job_issuer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  issuer_state_e state_q, state_d;
  logic [XW-1:0] core_x_q, core_x_d;
  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] out_data_q, out_data_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic [XW-1:0] fifo_pop_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          wait_timeout;

  tanh_issuer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && !out_valid_q;

`ifdef TANH_ISSUER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wdog_q, wdog_d;
  logic           timeout_err_q, timeout_err_d;

  // Counter restarts on every WAIT entry since it idles at zero elsewhere.
  always_comb begin
    wait_timeout  = (state_q == ST_WAIT) && !core_done &&
                    (wdog_q == WDW'(TIMEOUT_CYCLES - 1));
    wdog_d        = (state_q == ST_WAIT) ? wdog_q + WDW'(1) : '0;
    timeout_err_d = timeout_err_q || wait_timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wait_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      core_x_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      core_x_q    <= core_x_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fifo_pop) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (core_done || wait_timeout) state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // core_done only matters in WAIT; strays elsewhere fall through untouched.
  always_comb begin
    core_x_d    = core_x_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (fifo_pop) begin
      core_x_d = fifo_pop_data;
    end
    if (state_q == ST_WAIT) begin
      if (core_done) begin
        out_data_d  = core_result;
        out_valid_d = 1'b1;
      end else if (wait_timeout) begin
        out_data_d  = TIMEOUT_RESULT;
        out_valid_d = 1'b1;
      end
    end
    if ((state_q == ST_HOLD) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    in_ready    = !fifo_full;
    core_start  = (state_q == ST_START);
    core_data_x = core_x_q;
    out_valid   = out_valid_q;
    out_data    = out_data_q;
    busy        = (state_q != ST_IDLE) || !fifo_empty;
  end

endmodule
